// File: rtl/mem_arb_pkg.sv
// Shared types and helpers for the unified memory port arbiter.
// Imported by the arbiter top and its byte-merge datapath.
package mem_arb_pkg;

    typedef enum logic [0:0] {
        IDLE      = 1'b0,
        RMW_WRITE = 1'b1
    } arb_state_t;

    localparam int          WORD_W     = 32;
    localparam int          BE_W       = WORD_W / 8;
    localparam logic [3:0]  BE_FULL    = 4'hF;
    localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

    function automatic logic [WORD_W-1:0] byte_merge(
        input logic [WORD_W-1:0] old_w,
        input logic [WORD_W-1:0] new_w,
        input logic [BE_W-1:0]   be
    );
        logic [WORD_W-1:0] res;
        res = old_w;
        for (int i = 0; i < BE_W; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_w[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/mem_byte_merge.sv
// Per-lane merge of store data into the word read back from memory.
// Lanes with be set take the new data, the rest keep the old word.
module mem_byte_merge
    import mem_arb_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0]   old_i,
    input  logic [DATA_W-1:0]   new_i,
    input  logic [DATA_W/8-1:0] be_i,
    output logic [DATA_W-1:0]   merged_o
);

    for (genvar i = 0; i < DATA_W / 8; i++) begin : g_lane
        assign merged_o[8*i +: 8] = be_i[i] ? new_i[8*i +: 8]
                                            : old_i[8*i +: 8];
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Arbitrates the single memory port between fetch and load/store,
// with a fetch starvation bound and read-modify-write partial stores.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic                clk,
    input  logic                reset_n,
    input  logic                if_req,
    input  logic [ADDR_W-1:0]   if_addr,
    output logic                if_gnt,
    output logic                if_rvalid,
    output logic [DATA_W-1:0]   if_rdata,
    input  logic                d_req,
    input  logic                d_we,
    input  logic [DATA_W/8-1:0] d_be,
    input  logic [ADDR_W-1:0]   d_addr,
    input  logic [DATA_W-1:0]   d_wdata,
    output logic                d_gnt,
    output logic                d_rvalid,
    output logic [DATA_W-1:0]   d_rdata,
    output logic [ADDR_W-1:0]   mem_addr,
    output logic                mem_we,
    output logic [DATA_W-1:0]   mem_wdata,
    input  logic [DATA_W-1:0]   mem_rdata
);

    localparam int CNT_W = $clog2(MAX_WAIT + 1);
    localparam int NBE   = DATA_W / 8;
    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_WAIT);

    arb_state_t        state_q, state_d;
    logic [CNT_W-1:0]  starve_q, starve_d;
    logic              if_rvalid_q, if_rvalid_d;
    logic              d_rvalid_q, d_rvalid_d;
    logic [DATA_W-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
    logic [DATA_W-1:0] merge_q, merge_d;
    logic [ADDR_W-1:0] addr_q, addr_d;

    logic              in_rmw;
    logic              gnt_ok;
    logic              d_win;
    logic              be_full;
    logic              be_none;
    logic              full_wr;
    logic              partial;
    logic [ADDR_W-1:0] if_addr_al;
    logic [ADDR_W-1:0] d_addr_al;
    logic [DATA_W-1:0] merged;

    mem_byte_merge #(
        .DATA_W (DATA_W)
    ) u_merge (
        .old_i    (mem_rdata),
        .new_i    (d_wdata),
        .be_i     (d_be),
        .merged_o (merged)
    );

    assign if_addr_al = {if_addr[ADDR_W-1:2], 2'b00};
    assign d_addr_al  = {d_addr[ADDR_W-1:2], 2'b00};
    assign be_full    = (d_be == {NBE{1'b1}});
    assign be_none    = (d_be == '0);
    assign in_rmw     = (state_q == RMW_WRITE);

    // Grants are suppressed combinationally while reset is held.
    assign gnt_ok  = reset_n && !in_rmw;
    assign d_win   = d_req && !(if_req && starve_q == MAX_CNT);
    assign d_gnt   = gnt_ok && d_win;
    assign if_gnt  = gnt_ok && if_req && !d_win;
    assign full_wr = d_gnt && d_we && be_full;
    assign partial = d_gnt && d_we && !be_full && !be_none;

    always_comb begin
        mem_addr  = if_addr_al;
        mem_wdata = '0;
        if (in_rmw) begin
            mem_addr  = addr_q;
            mem_wdata = merge_q;
        end else if (d_gnt) begin
            mem_addr = d_addr_al;
            if (full_wr) begin
                mem_wdata = d_wdata;
            end
        end
    end

    assign mem_we = reset_n && (in_rmw || full_wr);

    always_comb begin
        state_d     = IDLE;
        merge_d     = merge_q;
        addr_d      = addr_q;
        if_rvalid_d = if_gnt;
        if_rdata_d  = if_gnt ? mem_rdata : if_rdata_q;
        d_rvalid_d  = (d_gnt && !partial) || in_rmw;
        d_rdata_d   = (d_gnt && !d_we) ? mem_rdata : d_rdata_q;
        starve_d    = '0;
        if (partial) begin
            state_d = RMW_WRITE;
            merge_d = merged;
            addr_d  = d_addr_al;
        end
        if (if_req && !if_gnt) begin
            starve_d = (starve_q == MAX_CNT) ? starve_q
                                             : starve_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            starve_q    <= '0;
            if_rvalid_q <= 1'b0;
            d_rvalid_q  <= 1'b0;
            if_rdata_q  <= '0;
            d_rdata_q   <= '0;
            merge_q     <= '0;
            addr_q      <= '0;
        end else begin
            state_q     <= state_d;
            starve_q    <= starve_d;
            if_rvalid_q <= if_rvalid_d;
            d_rvalid_q  <= d_rvalid_d;
            if_rdata_q  <= if_rdata_d;
            d_rdata_q   <= d_rdata_d;
            merge_q     <= merge_d;
            addr_q      <= addr_d;
        end
    end

    assign if_rvalid = if_rvalid_q;
    assign if_rdata  = if_rdata_q;
    assign d_rvalid  = d_rvalid_q;
    assign d_rdata   = d_rdata_q;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single-port unified instruction/data memory between the instruction-fetch requester and the load/store requester.
- Data accesses have priority; a starvation counter bounds fetch wait.
- Partial-word stores (sb/sh) are implemented as a two-cycle read-modify-write.
- Sits between the pipeline fetch/memory stages and the memory array. The memory has a combinational read, a synchronous write and word indexing by byte address >> 2.

Parameters:
- ADDR_W, 32, byte-address width of all address ports
- DATA_W, 32, word width; byte-enable width is DATA_W/8
- MAX_WAIT, 4, consecutive cycles a pending fetch may lose before it is forced to win

Ports:
- clk  input  1  system clock, rising edge
- reset_n  input  1  asynchronous active-low reset
- if_req  input  1  fetch request; held with if_addr until if_gnt
- if_addr  input  ADDR_W  fetch byte address
- if_gnt  output  1  fetch accepted this cycle
- if_rvalid  output  1  one-cycle pulse; if_rdata valid
- if_rdata  output  DATA_W  fetched word
- d_req  input  1  data request; payload held until d_gnt
- d_we  input  1  1=store, 0=load
- d_be  input  DATA_W/8  store byte enables; be[i] selects bits 8i+7:8i
- d_addr  input  ADDR_W  data byte address
- d_wdata  input  DATA_W  store data, already lane-aligned
- d_gnt  output  1  data request accepted this cycle
- d_rvalid  output  1  one-cycle pulse; load data valid or store complete
- d_rdata  output  DATA_W  loaded word
- mem_addr  output  ADDR_W  memory byte address, low 2 bits forced 0
- mem_we  output  1  memory write enable
- mem_wdata  output  DATA_W  memory write data
- mem_rdata  input  DATA_W  memory combinational read data

Behaviour:
- Clocking and reset: single clock clk. Reset reset_n is asynchronous, active-low.
- Reset values: state=IDLE, if_rvalid=0, d_rvalid=0, if_rdata=0, d_rdata=0, starve_cnt=0, merge register=0.
- While reset_n=0: if_gnt, d_gnt and mem_we are forced to 0.
- States: IDLE and RMW_WRITE.
- IDLE arbitration:
  - If only one request is present, that request is granted.
  - If both are present, data wins unless starve_cnt==MAX_WAIT, in which case fetch wins.
  - At most one grant per cycle.
  - Grants are combinational in the accepting cycle.
- Default drive: with no grant, mem_addr = if_addr with low 2 bits cleared, mem_we=0, mem_wdata=0.
- Fetch or load grant: mem_addr = addr & ~3, mem_we=0. mem_rdata is registered at that edge. The matching rvalid pulses for exactly the next cycle with rdata. Latency is 1 cycle. rdata holds its value until the next read.
- Full store (d_be all ones): in the grant cycle mem_we=1 and mem_wdata=d_wdata. d_rvalid pulses the next cycle and d_rdata is unchanged.
- Empty store (d_be=0): granted, no memory write, d_rvalid pulses the next cycle.
- Partial store: read-modify-write.
  - Grant cycle (IDLE): read access. The merge register captures, per byte, d_wdata where be=1 and mem_rdata where be=0. Address is captured. Next state is RMW_WRITE.
  - RMW_WRITE: mem_addr = captured address, mem_we=1, mem_wdata = merge register. No grants are issued. Next state is IDLE.
  - d_rvalid pulses the cycle after RMW_WRITE. Total occupancy is 2 cycles, completion at 3.
- Load ignores d_be.
- starve_cnt:
  - Increments (saturating at MAX_WAIT) on each cycle with if_req=1 and if_gnt=0, including RMW_WRITE cycles.
  - Clears on if_gnt or if_req=0.
- Back-to-back: a new grant is allowed in the cycle an rvalid pulses, so throughput is 1 access per cycle except during RMW.
- Reset mid-RMW: the pending write is dropped and no d_rvalid is issued.
- A fetch and a store to the same word in consecutive cycles: the fetch sees post-write data, because the memory write lands at the edge ending the store cycle.

Decomposition:
- Package mem_arb_pkg holds:
  - state enum {IDLE, RMW_WRITE}
  - BE_FULL constant
  - word-align mask
  - function byte_merge(old, new, be)
- One natural sub-module, mem_byte_merge: the combinational per-lane merge used for the RMW data. The arbiter FSM, counter and response registers stay in the top module.

Test Plan:
- Fetch only: if_req=1, if_addr=0x0000_0106, memory word 0x41 = 0xDEADBEEF -> if_gnt same cycle; mem_addr=0x104; next cycle if_rvalid=1 and if_rdata=0xDEADBEEF.
- Simultaneous requests: if_req=1 and d_req=1 (load 0x200) -> d_gnt first; if_gnt the following cycle; starve_cnt returns to 0.
- Starvation, MAX_WAIT=4: fetch held, d_req held high with continuous loads -> loads granted for 4 cycles; 5th cycle if_gnt=1 and d_gnt=0.
- Partial store: word 0x300 = 0x11223344, store d_be=4'b0010, d_wdata=0x0000AB00 -> RMW_WRITE writes 0x1122AB44; d_rvalid 2 cycles after grant; no grants during RMW_WRITE; subsequent load returns 0x1122AB44.
- Full and empty store: d_be=4'hF, data 0xCAFEF00D -> mem_we in grant cycle and word updated. d_be=0 -> no mem_we, but d_rvalid still pulses.
- Reset mid-RMW: reset_n low during RMW_WRITE -> mem_we=0 immediately, word unchanged, no d_rvalid, state IDLE after release.
